i2d_buf: RTL

Fetch-to-decode pipeline buffer. It receives fetched PC / next-PC / instruction packets from the fetch stage over a valid/ready handshake and presents them to the decode stage over a second valid/ready handshake. It has two entries (main plus skid), so the fetch-side ready depends only on registered state, and a downstream stall costs no throughput. It sits between the IFU and the IDU, and an EXU jump flushes it.

---
 rtl/i2d_buf.sv | 120 ++++++++++++
 1 files changed

// File: rtl/i2d_buf.sv
// Fetch-to-decode two-entry skid buffer with flush on EXU redirect.
// Optional performance counters are enabled with `I2D_PERF_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif

module i2d_buf #(
  parameter int unsigned ADDR_W   = `ADDR_WIDTH,
  parameter int unsigned INST_W   = 32,
  parameter logic [INST_W-1:0] INST_NOP = 32'h0000_0013
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_ifu_valid,
  output logic              o_i2d_ready,
  input  logic [ADDR_W-1:0] i_ifu_pc,
  input  logic [ADDR_W-1:0] i_ifu_pc_next,
  input  logic [INST_W-1:0] i_ifu_inst,
  output logic              o_i2d_valid,
  input  logic              i_idu_ready,
  output logic [ADDR_W-1:0] o_i2d_pc,
  output logic [ADDR_W-1:0] o_i2d_pc_next,
  output logic [INST_W-1:0] o_i2d_inst,
  input  logic              i_exu_jmp_en
`ifdef I2D_PERF_EN
  ,
  output logic [31:0]       o_perf_stall_cnt,
  output logic [31:0]       o_perf_flush_cnt
`endif
);

  // Bit 0 is main valid, bit 1 is skid valid, so valid/ready come straight off flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   main_pc, main_pc_next, skid_pc, skid_pc_next;
  logic [INST_W-1:0]   main_inst, skid_inst;
  logic                acc, xfr;

  assign acc = i_ifu_valid & ~state_q[1];
  assign xfr = state_q[0] & i_idu_ready;

  assign o_i2d_valid   = state_q[0];
  assign o_i2d_ready   = ~state_q[1];
  assign o_i2d_pc      = main_pc;
  assign o_i2d_pc_next = main_pc_next;
  assign o_i2d_inst    = main_inst;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q      <= EMPTY;
      main_pc      <= ADDR_W'(`ADDR_INIT);
      main_pc_next <= ADDR_W'(`ADDR_INIT);
      main_inst    <= INST_NOP;
      skid_pc      <= ADDR_W'(`ADDR_INIT);
      skid_pc_next <= ADDR_W'(`ADDR_INIT);
      skid_inst    <= INST_NOP;
    end else if (i_exu_jmp_en) begin
      // Redirect drops both entries; data is left stale behind cleared valids.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_pc      <= i_ifu_pc;
            main_pc_next <= i_ifu_pc_next;
            main_inst    <= i_ifu_inst;
            state_q      <= ONE;
          end
        end
        ONE: begin
          if (acc && xfr) begin
            main_pc      <= i_ifu_pc;
            main_pc_next <= i_ifu_pc_next;
            main_inst    <= i_ifu_inst;
          end else if (acc) begin
            skid_pc      <= i_ifu_pc;
            skid_pc_next <= i_ifu_pc_next;
            skid_inst    <= i_ifu_inst;
            state_q      <= FULL;
          end else if (xfr) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (xfr) begin
            main_pc      <= skid_pc;
            main_pc_next <= skid_pc_next;
            main_inst    <= skid_inst;
            state_q      <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef I2D_PERF_EN
  // Saturating stall and flush event counters.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      o_perf_stall_cnt <= 32'd0;
      o_perf_flush_cnt <= 32'd0;
    end else begin
      if (state_q[0] && !i_idu_ready && (o_perf_stall_cnt != 32'hFFFF_FFFF))
        o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
      if (i_exu_jmp_en && (state_q != EMPTY) && (o_perf_flush_cnt != 32'hFFFF_FFFF))
        o_perf_flush_cnt <= o_perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
